// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The BITS-wide operation is split into NSTG groups of GROUP bits. One group is
// resolved per stage, and the inter-group carry is registered between stages.
// valid/ready handshakes are provided on both sides. A stalled output freezes
// the whole pipeline.
module pipelined_cla_addsub #(
    parameter int BITS  = 16,
    parameter int GROUP = 4,
    parameter int NSTG  = BITS / GROUP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            cin,
    input  logic            op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] S,
    output logic            cout,
    output logic            ovf,
    output logic            zero
);

    // Every stage moves together; a held output holds every stage behind it.
    logic advance;

    assign in_ready = out_ready | ~out_valid;
    assign advance  = in_ready;

    // Flattened group lookahead. Each carry is built directly from g/p and the
    // group carry-in, so no carry depends on a neighbouring carry.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int unsigned j = 0; j < GROUP; j++) begin
            // Generate at bit i propagated through bits i+1..j.
            for (int unsigned i = 0; i <= j; i++) begin
                term = g[i];
                for (int unsigned m = i + 1; m <= j; m++) begin
                    term = term & p[m];
                end
                c[j+1] = c[j+1] | term;
            end
            // Group carry-in propagated through bits 0..j.
            term = c0;
            for (int unsigned m = 0; m <= j; m++) begin
                term = term & p[m];
            end
            c[j+1] = c[j+1] | term;
        end
        return c;
    endfunction

    for (genvar k = 0; k < NSTG; k++) begin : stg
        // Operand bits still to be consumed, counted from this stage's group upward.
        localparam int W = BITS - k * GROUP;

        // The word carries the finished sum bits below this group and the
        // unconsumed A bits from this group upward. The remaining B bits travel
        // separately and shrink by one group per stage.
        logic [BITS-1:0]  word_src;
        logic [W-1:0]     b_src;
        logic             c_src;
        logic             v_src;

        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic [GROUP-1:0] s_grp;
        logic [BITS-1:0]  word_nxt;

        logic [BITS-1:0]  word_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : src
            // Subtraction is A + ~B + ~cin. Inverting the borrow-in turns it into a carry-in.
            assign word_src = A;
            assign b_src    = op ? ~B : B;
            assign c_src    = op ? ~cin : cin;
            assign v_src    = in_valid;
        end else begin : src
            assign word_src = stg[k-1].word_q;
            assign b_src    = stg[k-1].bq.b_q;
            assign c_src    = stg[k-1].c_q;
            assign v_src    = stg[k-1].v_q;
        end

        // Resolve this stage's group and splice its sum bits into the word.
        always_comb begin
            g        = word_src[k*GROUP +: GROUP] & b_src[GROUP-1:0];
            p        = word_src[k*GROUP +: GROUP] ^ b_src[GROUP-1:0];
            c        = lookahead(g, p, c_src);
            s_grp    = p ^ c[GROUP-1:0];
            word_nxt = word_src;
            word_nxt[k*GROUP +: GROUP] = s_grp;
        end

        // Stage register: partial word, group carry-out and slot valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                word_q <= '0;
                c_q    <= 1'b0;
            end else if (advance) begin
                v_q    <= v_src;
                word_q <= word_nxt;
                c_q    <= c[GROUP];
            end
        end

        if (k < NSTG - 1) begin : bq
            logic [W-GROUP-1:0] b_q;

            // Forward only the B bits the later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (advance) begin
                    b_q <= b_src[W-1:GROUP];
                end
            end
        end else begin : last
            logic ovf_q;
            logic zero_q;

            // The status flags use the carries around the top bit and the complete sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= c[GROUP-1] ^ c[GROUP];
                    zero_q <= (word_nxt == '0);
                end
            end

            assign S         = word_q;
            assign cout      = c_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
            assign out_valid = v_q;
        end
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Splits the BITS-wide operation into BITS/GROUP carry-lookahead groups. One group is resolved per pipeline stage, and the inter-group carry is registered between stages.
- Produces sum, carry-out, signed overflow and zero flags.
- Serves as the arithmetic core of the ALU datapath where a single-cycle full-width carry chain misses timing.

Parameters:
- BITS, 16, operand width; must be a multiple of GROUP.
- GROUP, 4, width of one lookahead group (bits resolved per stage).
- NSTG, BITS/GROUP, derived pipeline depth; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- A  input  BITS  operand A, signed two's complement
- B  input  BITS  operand B, signed two's complement
- cin  input  1  carry-in (add) / borrow-in (sub)
- op  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- S  output  BITS  result
- cout  output  1  carry-out (add) / NOT borrow-out (sub)
- ovf  output  1  signed overflow
- zero  output  1  S == 0

Behaviour:
- Clocking and reset: single clock domain; rst is synchronous and active-high.
  - While rst is high at a clock edge, all stage valid bits, out_valid, S, cout, ovf and zero are cleared to 0.
  - Reset mid-operation discards every in-flight transaction; none emerges after reset.
- Operand mapping on acceptance: Beff = op ? ~B : B; c0 = op ? ~cin : cin.
  - Add computes A + B + cin.
  - Sub computes A - B - cin.
- Stage k (k = 0..NSTG-1) handles bits [k*GROUP +: GROUP]:
  - Per bit: g = a & b, p = a ^ b.
  - Group carries c[j+1] = g[j] | (p[j] & c[j]), flattened lookahead inside the group with no ripple.
  - Sum bit s = p ^ c.
  - Registers the group sum bits, the group carry-out, and the not-yet-consumed upper operand bits.
- Last stage additionally registers:
  - cout = carry out of bit BITS-1.
  - ovf = carry into bit BITS-1 XOR carry out of bit BITS-1.
  - zero = (full S == 0).
- Latency: exactly NSTG cycles from the accepting edge (in_valid & in_ready) to out_valid = 1, absent stalls. Throughput is one transaction per cycle.
- Handshake:
  - Transfer occurs at a clock edge where valid & ready are both 1.
  - in_ready = out_ready | ~out_valid, combinational.
  - Stall: when out_valid & ~out_ready, every stage holds its contents and valid bits. S, cout, ovf and zero stay stable while out_valid = 1 and out_ready = 0.
  - Empty pipeline slots (bubbles) advance normally when not stalled; they are not compressed.
  - Simultaneous accept and output-drain in the same cycle is legal and loses nothing.
  - in_valid is ignored when in_ready = 0; operand values are don't-care when in_valid = 0.
- Wrap-around: S is the low BITS bits of the true result (modular). cout and ovf report the lost information.
- With NSTG = 1 the block degenerates to a single registered CLA with the same handshake.

Test Plan:
(BITS=16, GROUP=4, latency 4)
- Reset: hold rst 3 cycles with in_valid=1 → out_valid, S, cout, ovf, zero all 0; after release, first result appears exactly 4 cycles after the first accept.
- Add with carry across all groups: A=0x0FFF, B=0x0001, cin=0, op=0 → S=0x1000, cout=0, ovf=0, zero=0; then A=0xFFFF, B=0x0001 → S=0x0000, cout=1, ovf=0, zero=1.
- Signed overflow: A=0x7FFF, B=0x0001, op=0 → S=0x8000, ovf=1, cout=0; sub A=0x8000, B=0x0001, cin=0 → S=0x7FFF, ovf=1, cout=1.
- Subtract with borrow: A=0x0005, B=0x0007, cin=1, op=1 → S=0xFFFD, cout=0, ovf=0; A=0x1234, B=0x1234, cin=0 → S=0, zero=1, cout=1.
- Back-pressure: stream 8 back-to-back transactions, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 during the stall, outputs held stable, all 8 results emerge in order with none lost or duplicated.
- Random regression: 10k random A/B/cin/op with random in_valid/out_ready; scoreboard against a behavioural model for S, cout, ovf and zero; assert reset mid-stream flushes all pending results.
